submarine_grid_engine: RTL and testbench

Parametrised game engine for the submarine-hunt game, succeeding the fixed 6x6, preset-map engine. Submarines are placed at runtime through a placement handshake; shots are then resolved one at a time.
- Each shot reports one of: hit, sink, miss, repeat, or error.
- done asserts when the whole fleet is sunk.
- Sits between the player-input front end and the display/score logic.

---
 rtl/submarine_grid_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_submarine_grid_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/submarine_grid_engine.sv
// Submarine-hunt game engine: runtime fleet placement followed by one-at-a-time shot resolution.
// Defining SHOT_LIMIT_EN adds the out_of_shots port and ends the game after MAX_SHOTS shots.
module submarine_grid_engine #(
  parameter int unsigned GRID      = 6,
  parameter int unsigned NUM_SUBS  = 4,
  parameter int unsigned MAX_LEN   = 4,
  parameter int unsigned MAX_SHOTS = 36,
  parameter int unsigned COORD_W   = $clog2(GRID),
  parameter int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             place_valid,
  input  logic [COORD_W-1:0]               place_x,
  input  logic [COORD_W-1:0]               place_y,
  input  logic [LEN_W-1:0]                 place_len,
  input  logic                             place_vert,
  output logic                             place_err,
  input  logic                             start,
  input  logic [COORD_W-1:0]               x,
  input  logic [COORD_W-1:0]               y,
  input  logic                             cord_valid,
  output logic                             busy,
  output logic                             hit,
  output logic                             sink,
  output logic                             miss,
  output logic                             repeat_shot,
  output logic                             shot_err,
  output logic [$clog2(NUM_SUBS+1)-1:0]    subs_left,
  output logic [$clog2(GRID*GRID+1)-1:0]   shot_cnt,
`ifdef SHOT_LIMIT_EN
  output logic                             out_of_shots,
`endif
  output logic                             done
);

  localparam int unsigned Cells = GRID * GRID;
  localparam int unsigned CellW = (Cells > 1) ? $clog2(Cells) : 1;
  localparam int unsigned IdW   = $clog2(NUM_SUBS + 1);
  localparam int unsigned SubW  = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1;
  localparam int unsigned CntW  = $clog2(Cells + 1);

  typedef enum logic [2:0] {
    StLoad, StPcheck, StPwrite, StPlay, StResolve, StReport, StDone
  } state_e;

  state_e state_q, state_d;

  logic [IdW-1:0]     cell_id_q [Cells];
  logic [Cells-1:0]   cell_shot_q;
  logic [LEN_W-1:0]   sub_rem_q [NUM_SUBS];
  logic [COORD_W-1:0] px_q, py_q, sx_q, sy_q;
  logic [LEN_W-1:0]   plen_q, idx_q;
  logic               pvert_q;
  logic               place_err_q, hit_q, sink_q, miss_q, rep_q, serr_q, done_q;
  logic [IdW-1:0]     subs_left_q;
  logic [CntW-1:0]    shot_cnt_q;

  logic [31:0]        span_end, cross_coord, walk_x, walk_y;
  logic               place_ok;
  logic [CellW-1:0]   walk_idx, shot_idx;
  logic [IdW-1:0]     walk_id, new_id, shot_id;
  logic [SubW-1:0]    shot_sub;
  logic               shot_in, shot_seen, res_new, res_hit, res_sink;
  logic               game_over, limit_hit;
  logic [CntW-1:0]    cnt_next;
  logic               place_acc, place_rej, shot_acc;

  // Request screening: the far end of the hull and the fixed coordinate must both lie on the board.
  assign span_end    = (place_vert ? 32'(place_y) : 32'(place_x)) + 32'(place_len);
  assign cross_coord = place_vert ? 32'(place_x) : 32'(place_y);
  assign place_ok    = (place_len != '0) && (32'(place_len) <= MAX_LEN) && (span_end <= GRID) &&
                       (cross_coord < GRID) && (32'(subs_left_q) < NUM_SUBS);

  // Cell under the placement walker; the new sub takes the next free id.
  assign walk_x   = 32'(px_q) + (pvert_q ? 32'd0 : 32'(idx_q));
  assign walk_y   = 32'(py_q) + (pvert_q ? 32'(idx_q) : 32'd0);
  assign walk_idx = CellW'(walk_y * GRID + walk_x);
  assign walk_id  = cell_id_q[walk_idx];
  assign new_id   = subs_left_q + IdW'(1);

  assign shot_in   = (32'(sx_q) < GRID) && (32'(sy_q) < GRID);
  assign shot_idx  = CellW'(32'(sy_q) * GRID + 32'(sx_q));
  assign shot_id   = cell_id_q[shot_idx];
  assign shot_seen = cell_shot_q[shot_idx];
  assign shot_sub  = SubW'(shot_id - IdW'(1));
  assign res_new   = shot_in && !shot_seen;
  assign res_hit   = res_new && (shot_id != '0);
  assign res_sink  = res_hit && (sub_rem_q[shot_sub] == LEN_W'(1));
  assign cnt_next  = (res_new && (32'(shot_cnt_q) < Cells)) ? shot_cnt_q + CntW'(1) : shot_cnt_q;
  assign game_over = res_sink && (subs_left_q == IdW'(1));

`ifdef SHOT_LIMIT_EN
  logic oos_q;
  // A fleet-sinking final shot wins even when it also exhausts the budget.
  assign limit_hit    = res_new && (32'(cnt_next) == MAX_SHOTS) && !game_over;
  assign out_of_shots = oos_q;
`else
  logic unused_max_shots;
  assign limit_hit        = 1'b0;
  assign unused_max_shots = ^MAX_SHOTS;
`endif

  always_comb begin
    state_d   = state_q;
    place_acc = 1'b0;
    place_rej = 1'b0;
    shot_acc  = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (start && (subs_left_q != '0)) begin
          state_d = StPlay;
        end else if (place_valid) begin
          if (place_ok) begin
            place_acc = 1'b1;
            state_d   = StPcheck;
          end else begin
            place_rej = 1'b1;
          end
        end
      end
      StPcheck: begin
        if (walk_id != '0) begin
          place_rej = 1'b1;
          state_d   = StLoad;
        end else if (idx_q == plen_q - LEN_W'(1)) begin
          state_d = StPwrite;
        end
      end
      // idx_q == plen_q is the commit cycle after the last cell write.
      StPwrite: begin
        if (idx_q == plen_q) state_d = StLoad;
      end
      StPlay, StReport: begin
        state_d = StPlay;
        if (cord_valid) begin
          shot_acc = 1'b1;
          state_d  = StResolve;
        end
      end
      StResolve: state_d = (game_over || limit_hit) ? StDone : StReport;
      StDone:    state_d = StDone;
      default:   state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StLoad;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cell_id_q   <= '{default: '0};
      cell_shot_q <= '0;
      sub_rem_q   <= '{default: '0};
      px_q        <= '0;
      py_q        <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      plen_q      <= '0;
      idx_q       <= '0;
      pvert_q     <= 1'b0;
      place_err_q <= 1'b0;
      hit_q       <= 1'b0;
      sink_q      <= 1'b0;
      miss_q      <= 1'b0;
      rep_q       <= 1'b0;
      serr_q      <= 1'b0;
      done_q      <= 1'b0;
      subs_left_q <= '0;
      shot_cnt_q  <= '0;
`ifdef SHOT_LIMIT_EN
      oos_q       <= 1'b0;
`endif
    end else begin
      place_err_q <= place_rej;
      hit_q       <= 1'b0;
      sink_q      <= 1'b0;
      miss_q      <= 1'b0;
      rep_q       <= 1'b0;
      serr_q      <= 1'b0;
      if (place_acc) begin
        px_q    <= place_x;
        py_q    <= place_y;
        plen_q  <= place_len;
        pvert_q <= place_vert;
        idx_q   <= '0;
      end
      if (state_q == StPcheck) begin
        idx_q <= (state_d == StPwrite) ? '0 : idx_q + LEN_W'(1);
      end
      if (state_q == StPwrite) begin
        if (idx_q == plen_q) begin
          sub_rem_q[SubW'(subs_left_q)] <= plen_q;
          subs_left_q                   <= new_id;
        end else begin
          cell_id_q[walk_idx] <= new_id;
          idx_q               <= idx_q + LEN_W'(1);
        end
      end
      if (shot_acc) begin
        sx_q <= x;
        sy_q <= y;
      end
      if (state_q == StResolve) begin
        serr_q     <= !shot_in;
        rep_q      <= shot_in && shot_seen;
        miss_q     <= res_new && (shot_id == '0);
        hit_q      <= res_hit;
        sink_q     <= res_sink;
        shot_cnt_q <= cnt_next;
        if (res_new) cell_shot_q[shot_idx] <= 1'b1;
        if (res_hit) sub_rem_q[shot_sub] <= sub_rem_q[shot_sub] - LEN_W'(1);
        if (res_sink) subs_left_q <= subs_left_q - IdW'(1);
        if (game_over || limit_hit) done_q <= 1'b1;
`ifdef SHOT_LIMIT_EN
        if (limit_hit) oos_q <= 1'b1;
`endif
      end
    end
  end

  assign busy        = (state_q == StPcheck) || (state_q == StPwrite) ||
                       (state_q == StResolve) || (state_q == StDone);
  assign place_err   = place_err_q;
  assign hit         = hit_q;
  assign sink        = sink_q;
  assign miss        = miss_q;
  assign repeat_shot = rep_q;
  assign shot_err    = serr_q;
  assign subs_left   = subs_left_q;
  assign shot_cnt    = shot_cnt_q;
  assign done        = done_q;

endmodule

// File: tb/tb_submarine_grid_engine.sv
// Directed bench for submarine_grid_engine: placement, shot results and game end.
// Shot expectations go through a scoreboard queue; define SHOT_LIMIT_EN to test the shot budget.
module tb_submarine_grid_engine;

  localparam int unsigned GRID     = 6;
  localparam int unsigned NUM_SUBS = 4;
  localparam int unsigned MAX_LEN  = 4;
`ifdef SHOT_LIMIT_EN
  localparam int unsigned MAX_SHOTS = 5;
`else
  localparam int unsigned MAX_SHOTS = 36;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       place_valid, place_vert, start, cord_valid;
  logic [2:0] place_x, place_y, place_len, x, y;
  logic       place_err, busy, hit, sink, miss, repeat_shot, shot_err, done;
  logic [2:0] subs_left;
  logic [5:0] shot_cnt;
`ifdef SHOT_LIMIT_EN
  logic       out_of_shots;
`endif

  typedef struct {
    logic [4:0] flags;  // {hit, sink, miss, repeat_shot, shot_err}
    int         cnt;
    int         subs;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  submarine_grid_engine #(
    .GRID      (GRID),
    .NUM_SUBS  (NUM_SUBS),
    .MAX_LEN   (MAX_LEN),
    .MAX_SHOTS (MAX_SHOTS)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .place_valid (place_valid),
    .place_x     (place_x),
    .place_y     (place_y),
    .place_len   (place_len),
    .place_vert  (place_vert),
    .place_err   (place_err),
    .start       (start),
    .x           (x),
    .y           (y),
    .cord_valid  (cord_valid),
    .busy        (busy),
    .hit         (hit),
    .sink        (sink),
    .miss        (miss),
    .repeat_shot (repeat_shot),
    .shot_err    (shot_err),
    .subs_left   (subs_left),
    .shot_cnt    (shot_cnt),
`ifdef SHOT_LIMIT_EN
    .out_of_shots(out_of_shots),
`endif
    .done        (done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] cur_flags();
    return {hit, sink, miss, repeat_shot, shot_err};
  endfunction

  // Issue one placement; count busy cycles and sample place_err once busy drops.
  task automatic place(input string tag, input int px, input int py, input int len,
                       input bit vert, input int exp_busy, input bit exp_err);
    int   n;
    logic pe;
    place_x     = 3'(px);
    place_y     = 3'(py);
    place_len   = 3'(len);
    place_vert  = vert;
    place_valid = 1'b1;
    tick();
    place_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    pe = place_err;
    check({tag, " busy cycles"}, n, exp_busy);
    check({tag, " place_err"}, int'(pe), int'(exp_err));
    tick();
    check({tag, " place_err width"}, int'(place_err), 0);
  endtask

  // Fire one shot; poke holds cord_valid (retargeted) through the busy cycle, which must be dropped.
  task automatic shoot(input string tag, input int sx, input int sy, input logic [4:0] flags,
                       input int cnt, input int subs, input logic dn, input bit poke);
    exp_t       e;
    int         lat;
    logic [4:0] f;
    e.flags = flags;
    e.cnt   = cnt;
    e.subs  = subs;
    e.dn    = dn;
    sb.push_back(e);
    x          = 3'(sx);
    y          = 3'(sy);
    cord_valid = 1'b1;
    tick();
    if (poke) begin
      x = 3'd3;
      y = 3'd3;
    end else begin
      cord_valid = 1'b0;
    end
    check({tag, " busy in resolve"}, int'(busy), 1);
    lat = 1;
    f   = cur_flags();
    while (f == 5'b0 && lat < 8) begin
      tick();
      cord_valid = 1'b0;
      lat++;
      f = cur_flags();
    end
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, " result flags"}, int'(f), int'(e.flags));
      check({tag, " latency"}, lat, 2);
      check({tag, " shot_cnt"}, int'(shot_cnt), e.cnt);
      check({tag, " subs_left"}, int'(subs_left), e.subs);
      check({tag, " done"}, int'(done), int'(e.dn));
    end
    tick();
    check({tag, " pulse width"}, int'(cur_flags()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] acc;
    place_valid = 1'b0;
    place_vert  = 1'b0;
    place_x     = '0;
    place_y     = '0;
    place_len   = '0;
    start       = 1'b0;
    cord_valid  = 1'b0;
    x           = '0;
    y           = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset place_err", int'(place_err), 0);
    check("reset flags", int'(cur_flags()), 0);
    check("reset subs_left", int'(subs_left), 0);
    check("reset shot_cnt", int'(shot_cnt), 0);
    check("reset done", int'(done), 0);
`ifdef SHOT_LIMIT_EN
    check("reset out_of_shots", int'(out_of_shots), 0);
`endif
    rstn = 1'b1;
    tick();

    // start with an empty fleet must leave the engine in placement mode
    start = 1'b1;
    tick();
    start = 1'b0;
    place("len zero", 0, 0, 0, 1'b0, 0, 1'b1);
    place("len over", 0, 0, 5, 1'b0, 0, 1'b1);
    place("sub1 vert", 1, 1, 3, 1'b1, 7, 1'b0);
    place("sub2 horiz", 0, 5, 2, 1'b0, 5, 1'b0);
    check("subs after two", int'(subs_left), 2);
    place("overlap", 0, 2, 2, 1'b0, 2, 1'b1);
    place("off grid", 4, 0, 4, 1'b0, 0, 1'b1);
    check("subs after rejects", int'(subs_left), 2);

    start = 1'b1;
    tick();
    start = 1'b0;
    shoot("s1 (1,1)", 1, 1, 5'b10000, 1, 2, 1'b0, 1'b0);
    shoot("s2 (1,2)", 1, 2, 5'b10000, 2, 2, 1'b0, 1'b1);
    shoot("s3 (1,3)", 1, 3, 5'b11000, 3, 1, 1'b0, 1'b0);
    shoot("s4 repeat", 1, 1, 5'b00010, 3, 1, 1'b0, 1'b0);
    shoot("s5 range", 7, 0, 5'b00001, 3, 1, 1'b0, 1'b0);
    // (0,2) lies under the rejected overlap placement and must still be empty
    shoot("s6 (0,2)", 0, 2, 5'b00100, 4, 1, 1'b0, 1'b0);
`ifdef SHOT_LIMIT_EN
    shoot("s7 (0,5)", 0, 5, 5'b10000, 5, 1, 1'b1, 1'b0);
    check("out_of_shots", int'(out_of_shots), 1);
`else
    shoot("s7 (0,5)", 0, 5, 5'b10000, 5, 1, 1'b0, 1'b0);
    shoot("s8 (1,5)", 1, 5, 5'b11000, 6, 0, 1'b1, 1'b0);
`endif

    // Game over: every input is ignored.
    x           = 3'd1;
    y           = 3'd5;
    cord_valid  = 1'b1;
    start       = 1'b1;
    place_valid = 1'b1;
    acc         = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acc |= cur_flags();
      acc[0] |= place_err;
    end
    cord_valid  = 1'b0;
    start       = 1'b0;
    place_valid = 1'b0;
    check("after done pulses", int'(acc), 0);
    check("after done busy", int'(busy), 1);
    check("after done held", int'(done), 1);

    // Asynchronous reset takes effect without a clock edge.
    @(negedge clk);
    rstn = 1'b0;
    #2;
    check("async reset done", int'(done), 0);
    check("async reset subs", int'(subs_left), 0);
    check("async reset cnt", int'(shot_cnt), 0);
    check("async reset busy", int'(busy), 0);
    tick();
    rstn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
